// File: rtl/apb_master_arb.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_arb
// Function : Two-requester round-robin APB master. Optional ACCESS-phase
//            timeout is enabled with `define APB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module apb_master_arb #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                pclk,
    input  logic                prst,
    input  logic [1:0]          req_valid,
    input  logic [1:0]          req_wr,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          req_ready,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                psel,
    output logic                penable,
    output logic                pwr,
    output logic [ADDR_W-1:0]   padd,
    output logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pready,
    input  logic                pslverr
);

    typedef enum logic [1:0] {
        c_IDLE   = 2'd0,
        c_SETUP  = 2'd1,
        c_ACCESS = 2'd2
    } state_t;

    state_t              r_state_q, w_state_d;
    logic                r_rr_q, w_rr_d;
    logic                r_gnt_q, w_gnt_d;
    logic                r_pwr_q, w_pwr_d;
    logic [ADDR_W-1:0]   r_padd_q, w_padd_d;
    logic [DATA_W-1:0]   r_pwdata_q, w_pwdata_d;
    logic [1:0]          r_rsp_valid_q, w_rsp_valid_d;
    logic [DATA_W-1:0]   r_rsp_rdata_q, w_rsp_rdata_d;
    logic                r_rsp_err_q, w_rsp_err_d;
    logic                w_sel, w_grant, w_xfer_end, w_abort;

`ifdef APB_TIMEOUT_EN
    logic [7:0]          r_cnt_q, w_cnt_d;
    assign w_abort = (r_state_q == c_ACCESS) && !pready && (r_cnt_q == 8'(TIMEOUT - 1));
`else
    logic                w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT == 0);
    assign w_abort          = 1'b0;
`endif

    // r_rr_q holds the requester that wins the next tie
    assign w_sel      = (req_valid == 2'b11) ? r_rr_q : req_valid[1];
    assign w_xfer_end = (r_state_q == c_ACCESS) && pready;
    assign w_grant    = prst && (req_valid != 2'b00) &&
                        ((r_state_q == c_IDLE) || w_xfer_end);
    assign req_ready  = w_grant ? (w_sel ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        w_state_d     = r_state_q;
        w_rr_d        = r_rr_q;
        w_gnt_d       = r_gnt_q;
        w_pwr_d       = r_pwr_q;
        w_padd_d      = r_padd_q;
        w_pwdata_d    = r_pwdata_q;
        w_rsp_valid_d = 2'b00;
        w_rsp_rdata_d = r_rsp_rdata_q;
        w_rsp_err_d   = r_rsp_err_q;
`ifdef APB_TIMEOUT_EN
        w_cnt_d       = r_cnt_q;
`endif
        case (r_state_q)
            c_IDLE: begin
                if (w_grant) w_state_d = c_SETUP;
            end
            c_SETUP: begin
                w_state_d = c_ACCESS;
`ifdef APB_TIMEOUT_EN
                w_cnt_d   = 8'd0;
`endif
            end
            c_ACCESS: begin
                if (w_xfer_end) begin
                    w_rsp_valid_d = r_gnt_q ? 2'b10 : 2'b01;
                    w_rsp_err_d   = pslverr;
                    w_rsp_rdata_d = r_pwr_q ? '0 : prdata;
                    w_state_d     = w_grant ? c_SETUP : c_IDLE;
                end else if (w_abort) begin
                    w_rsp_valid_d = r_gnt_q ? 2'b10 : 2'b01;
                    w_rsp_err_d   = 1'b1;
                    w_rsp_rdata_d = '0;
                    w_state_d     = c_IDLE;
                end
`ifdef APB_TIMEOUT_EN
                else begin
                    w_cnt_d = r_cnt_q + 8'd1;
                end
`endif
            end
            default: w_state_d = c_IDLE;
        endcase
        if (w_grant) begin
            w_gnt_d    = w_sel;
            w_rr_d     = ~w_sel;
            w_pwr_d    = req_wr[w_sel];
            w_padd_d   = w_sel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
            w_pwdata_d = w_sel ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
        end
    end

    always_ff @(posedge pclk) begin
        if (!prst) begin
            r_state_q     <= c_IDLE;
            r_rr_q        <= 1'b0;
            r_gnt_q       <= 1'b0;
            r_pwr_q       <= 1'b0;
            r_padd_q      <= '0;
            r_pwdata_q    <= '0;
            r_rsp_valid_q <= 2'b00;
            r_rsp_rdata_q <= '0;
            r_rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            r_cnt_q       <= 8'd0;
`endif
        end else begin
            r_state_q     <= w_state_d;
            r_rr_q        <= w_rr_d;
            r_gnt_q       <= w_gnt_d;
            r_pwr_q       <= w_pwr_d;
            r_padd_q      <= w_padd_d;
            r_pwdata_q    <= w_pwdata_d;
            r_rsp_valid_q <= w_rsp_valid_d;
            r_rsp_rdata_q <= w_rsp_rdata_d;
            r_rsp_err_q   <= w_rsp_err_d;
`ifdef APB_TIMEOUT_EN
            r_cnt_q       <= w_cnt_d;
`endif
        end
    end

    assign psel      = (r_state_q != c_IDLE);
    assign penable   = (r_state_q == c_ACCESS);
    assign pwr       = r_pwr_q;
    assign padd      = r_padd_q;
    assign pwdata    = r_pwdata_q;
    assign rsp_valid = r_rsp_valid_q;
    assign rsp_rdata = r_rsp_rdata_q;
    assign rsp_err   = r_rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master_arb
// Function : Self-checking bench for apb_master_arb: vector table, directed
//            multi-cycle sequences and a randomized run against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master_arb;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic        pclk = 1'b0;
    logic        prst;
    logic [1:0]  req_valid, req_wr, req_ready, rsp_valid;
    logic [15:0] req_addr;
    logic [63:0] req_wdata;
    logic [31:0] rsp_rdata, pwdata, prdata;
    logic        rsp_err, psel, penable, pwr, pready, pslverr;
    logic [7:0]  padd;

    apb_master_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .pclk(pclk), .prst(prst), .req_valid(req_valid), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwr(pwr), .padd(padd), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic do_reset();
        prst = 1'b0; req_valid = 2'b00; pready = 1'b0; pslverr = 1'b0;
        repeat (2) tick();
        prst = 1'b1;
    endtask

    typedef struct {
        logic [1:0]  valid;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata_in;
        logic        slverr;
        int          waits;
        logic [1:0]  exp_ready;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [6];

    // One complete transfer from a vector, checking every phase of it
    task automatic run_vec(input vec_t v);
        req_valid = v.valid; req_wr = {2{v.wr}}; req_addr = {2{v.addr}};
        req_wdata = {2{v.wdata}}; pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
        @(negedge pclk);
        check("vec_req_ready", req_ready, v.exp_ready);
        check("vec_idle_psel", psel, 1'b0);
        tick();
        req_valid = 2'b00;
        @(negedge pclk);
        check("vec_setup_psel", psel, 1'b1);
        check("vec_setup_penable", penable, 1'b0);
        check("vec_setup_padd", padd, v.addr);
        check("vec_setup_pwr", pwr, v.wr);
        check("vec_setup_pwdata", pwdata, v.wdata);
        tick();
        for (int w = 0; w <= v.waits; w++) begin
            pready  = (w == v.waits);
            pslverr = (w == v.waits) ? v.slverr : 1'b0;
            prdata  = (w == v.waits) ? v.rdata_in : $urandom;
            @(negedge pclk);
            check("vec_access_penable", penable, 1'b1);
            check("vec_access_padd", padd, v.addr);
            check("vec_access_no_rsp", rsp_valid, 2'b00);
            tick();
        end
        pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
        @(negedge pclk);
        check("vec_rsp_valid", rsp_valid, v.exp_ready);
        check("vec_rsp_rdata", rsp_rdata, v.exp_rdata);
        check("vec_rsp_err", rsp_err, v.exp_err);
        check("vec_rsp_psel", psel, 1'b0);
        tick();
        @(negedge pclk);
        check("vec_rsp_pulse", rsp_valid, 2'b00);
        check("vec_rdata_hold", rsp_rdata, v.exp_rdata);
        check("vec_err_hold", rsp_err, v.exp_err);
        tick();
    endtask

    // Transaction-level reference state for the randomized run
    logic        m_busy, m_ptr, m_cur_id, m_cur_wr, m_g;
    int          m_age;
    logic [7:0]  m_cur_addr;
    logic [31:0] m_cur_wdata, m_exp_rdata;
    logic [1:0]  m_exp_rsp, m_exp_ready, m_acc;
    logic        m_exp_err, m_end, m_abort;

    logic [1:0] exp_order [4];

    initial begin
        req_valid = 2'b00; req_wr = 2'b00; req_addr = '0; req_wdata = '0;
        prdata = '0; pready = 1'b0; pslverr = 1'b0; prst = 1'b0;

        vecs[0] = '{2'b01, 1'b1, 8'h10, 32'hDEADBEEF, 32'h0,        1'b0, 0, 2'b01, 32'h0,        1'b0};
        vecs[1] = '{2'b10, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0, 3, 2'b10, 32'hDEADBEEF, 1'b0};
        vecs[2] = '{2'b11, 1'b0, 8'h3F, 32'h0,        32'h12345678, 1'b1, 0, 2'b01, 32'h12345678, 1'b1};
        vecs[3] = '{2'b11, 1'b1, 8'h55, 32'hA5A5A5A5, 32'h0,        1'b0, 1, 2'b10, 32'h0,        1'b0};
        vecs[4] = '{2'b10, 1'b1, 8'hFF, 32'h11223344, 32'h99999999, 1'b1, 2, 2'b10, 32'h0,        1'b1};
        vecs[5] = '{2'b11, 1'b0, 8'h01, 32'h0,        32'hCAFEF00D, 1'b0, 0, 2'b01, 32'hCAFEF00D, 1'b0};

        repeat (3) tick();
        @(negedge pclk);
        check("rst_psel", psel, 1'b0);
        check("rst_penable", penable, 1'b0);
        check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_padd", padd, 8'h0);
        tick();
        prst = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Both requesters held: alternating back-to-back grants
        do_reset();
        exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01; exp_order[3] = 2'b10;
        req_valid = 2'b11; req_wr = 2'b00; req_addr = 16'hB1A0; pready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge pclk);
            check("b2b_grant", req_ready, exp_order[k]);
            check("b2b_psel", psel, k > 0);
            tick();
            if (k == 3) req_valid = 2'b00;
            @(negedge pclk);
            check("b2b_setup_psel", psel, 1'b1);
            check("b2b_setup_penable", penable, 1'b0);
            check("b2b_setup_ready", req_ready, 2'b00);
            check("b2b_padd", padd, (exp_order[k] == 2'b01) ? 8'hA0 : 8'hB1);
            check("b2b_rsp", rsp_valid, (k > 0) ? exp_order[k-1] : 2'b00);
            tick();
        end
        @(negedge pclk);
        check("b2b_last_penable", penable, 1'b1);
        check("b2b_last_ready", req_ready, 2'b00);
        tick();
        pready = 1'b0;
        @(negedge pclk);
        check("b2b_end_psel", psel, 1'b0);
        check("b2b_end_rsp", rsp_valid, 2'b10);
        tick();

        // Reset while in ACCESS aborts silently; tie then goes to requester 0
        do_reset();
        req_valid = 2'b01; req_wr = 2'b11; req_addr = 16'h2211; req_wdata = 64'h0;
        @(negedge pclk);
        check("rstmid_grant", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        tick();
        @(negedge pclk);
        check("rstmid_access", penable, 1'b1);
        tick();
        prst = 1'b0; pready = 1'b1; pslverr = 1'b1;
        tick();
        prst = 1'b1; pready = 1'b0; pslverr = 1'b0; req_valid = 2'b11;
        @(negedge pclk);
        check("rstmid_psel", psel, 1'b0);
        check("rstmid_penable", penable, 1'b0);
        check("rstmid_no_rsp", rsp_valid, 2'b00);
        check("rstmid_padd", padd, 8'h00);
        check("rstmid_tie_req0", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        @(negedge pclk);
        check("rstmid_still_no_rsp", rsp_valid, 2'b00);
        check("rstmid_new_padd", padd, 8'h11);
        tick();
        pready = 1'b1;
        tick();
        pready = 1'b0;
        @(negedge pclk);
        check("rstmid_rsp", rsp_valid, 2'b01);
        check("rstmid_rsp_err", rsp_err, 1'b0);
        tick();

`ifdef APB_TIMEOUT_EN
        do_reset();
        req_valid = 2'b10; req_wr = 2'b00; req_addr = 16'h4400; prdata = 32'h5A5A5A5A;
        tick();
        req_valid = 2'b00;
        tick();
        for (int k = 0; k < TIMEOUT; k++) begin
            @(negedge pclk);
            check("to_access_held", {psel, penable}, 2'b11);
            check("to_no_rsp", rsp_valid, 2'b00);
            tick();
        end
        @(negedge pclk);
        check("to_psel_drop", psel, 1'b0);
        check("to_rsp_valid", rsp_valid, 2'b10);
        check("to_rsp_err", rsp_err, 1'b1);
        check("to_rsp_rdata", rsp_rdata, 32'h0);
        tick();
`endif

        // Randomized traffic against the transaction-level model
        do_reset();
        m_busy = 1'b0; m_ptr = 1'b0; m_age = 0; m_exp_rsp = 2'b00; m_acc = 2'b00;
        m_exp_rdata = '0; m_exp_err = 1'b0; m_cur_id = 1'b0; m_cur_wr = 1'b0;
        m_cur_addr = '0; m_cur_wdata = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (m_acc[i]) req_valid[i] = 1'b0;
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        req_valid[i] = 1'b1;
                        req_wr[i] = 1'($urandom_range(0, 1));
                        req_addr[i*8 +: 8] = 8'($urandom);
                        req_wdata[i*32 +: 32] = $urandom;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            pready  = ($urandom_range(0, 4) != 0);
            pslverr = ($urandom_range(0, 3) == 0);
            prdata  = $urandom;
            @(negedge pclk);
            check("rnd_psel", psel, m_busy);
            check("rnd_penable", penable, m_busy && (m_age >= 1));
            if (m_busy) begin
                check("rnd_padd", padd, m_cur_addr);
                check("rnd_pwr", pwr, m_cur_wr);
                check("rnd_pwdata", pwdata, m_cur_wdata);
            end
            check("rnd_rsp_valid", rsp_valid, m_exp_rsp);
            check("rnd_rsp_rdata", rsp_rdata, m_exp_rdata);
            check("rnd_rsp_err", rsp_err, m_exp_err);
            m_end   = m_busy && (m_age >= 1) && pready;
            m_abort = 1'b0;
`ifdef APB_TIMEOUT_EN
            m_abort = m_busy && !pready && (m_age == TIMEOUT);
`endif
            m_g = (req_valid == 2'b11) ? m_ptr : req_valid[1];
            m_exp_ready = ((!m_busy || m_end) && (req_valid != 2'b00)) ? (2'b01 << m_g) : 2'b00;
            check("rnd_req_ready", req_ready, m_exp_ready);
            m_acc = m_exp_ready;
            m_exp_rsp = 2'b00;
            if (m_end) begin
                m_exp_rsp = 2'b01 << m_cur_id;
                m_exp_err = pslverr;
                m_exp_rdata = m_cur_wr ? 32'h0 : prdata;
            end else if (m_abort) begin
                m_exp_rsp = 2'b01 << m_cur_id;
                m_exp_err = 1'b1;
                m_exp_rdata = 32'h0;
            end
            if (m_exp_ready != 2'b00) begin
                m_cur_id = m_g; m_cur_wr = req_wr[m_g];
                m_cur_addr = m_g ? req_addr[15:8] : req_addr[7:0];
                m_cur_wdata = m_g ? req_wdata[63:32] : req_wdata[31:0];
                m_busy = 1'b1; m_age = 0; m_ptr = ~m_g;
            end else if (m_end || m_abort) begin
                m_busy = 1'b0;
            end else if (m_busy) begin
                m_age++;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
